// File: rtl/matmul_engine.sv
// matmul_engine: NxN C = A x B, SRAM-loaded operands, one MAC per cycle, valid/ready result stream; MATMUL_SIGNED_EN selects two's-complement arithmetic.
module matmul_engine #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = 11,
  parameter int BASE_A = 0,
  parameter int BASE_B = 16,
  localparam int LW    = $clog2(N),
  localparam int RW    = 2*DW + LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic [LW-1:0] res_row,
  output logic [LW-1:0] res_col,
  output logic          res_last
);
  localparam int EW = $clog2(N*N);
  localparam int CW = $clog2(2*N*N + 1);
  localparam logic [CW-1:0] NN   = CW'(N*N);
  localparam logic [CW-1:0] LAST = CW'(2*N*N);
  localparam logic [LW-1:0] KL   = LW'(N-1);
  localparam logic [EW-1:0] NE   = EW'(N);
  localparam logic [AW-1:0] BA   = AW'(BASE_A);
  localparam logic [AW-1:0] BB   = AW'(BASE_B);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]   cnt, rd_idx;
  logic            rd_valid;
  logic [LW-1:0]   i, j, k;
  logic [RW-1:0]   acc, prod_x;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   a_op, b_op;
  logic [DW-1:0]   a_mem [N*N];
  logic [DW-1:0]   b_mem [N*N];

  // Arrays keep the SRAM's column-major order, so the word offset is the array index.
  assign a_op = a_mem[EW'(k)*NE + EW'(i)];
  assign b_op = b_mem[EW'(j)*NE + EW'(k)];

`ifdef MATMUL_SIGNED_EN
  assign prod   = {{DW{a_op[DW-1]}}, a_op} * {{DW{b_op[DW-1]}}, b_op};
  assign prod_x = {{LW{prod[2*DW-1]}}, prod};
`else
  assign prod   = {{DW{1'b0}}, a_op} * {{DW{1'b0}}, b_op};
  assign prod_x = {{LW{1'b0}}, prod};
`endif

  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign res_valid = state == EMIT;
  assign res_last  = res_valid && res_row == KL && res_col == KL;
  assign mem_en    = state == LOAD && cnt < LAST;
  assign mem_addr  = !mem_en ? '0 : cnt < NN ? BA + AW'(cnt) : BB + AW'(cnt - NN);

  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = cnt == LAST ? MAC : LOAD;
      MAC:     state_n = k == KL ? EMIT : MAC;
      EMIT:    state_n = !res_ready ? EMIT : res_last ? DONE : MAC;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read data lags the issue cycle by one, so the issuing index rides along with it.
  always_ff @(posedge clk) begin
    if (rd_valid && rd_idx < NN) a_mem[EW'(rd_idx)] <= mem_rdata;
    if (rd_valid && rd_idx >= NN) b_mem[EW'(rd_idx - NN)] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      res_data <= '0;
      res_row  <= '0;
      res_col  <= '0;
    end else begin
      rd_valid <= mem_en;
      rd_idx   <= cnt;
      case (state)
        IDLE: cnt <= '0;
        LOAD: begin
          cnt <= cnt + CW'(1);
          i   <= '0;
          j   <= '0;
          k   <= '0;
          acc <= '0;
        end
        MAC: begin
          acc <= acc + prod_x;
          k   <= k == KL ? '0 : k + LW'(1);
          if (k == KL) begin
            res_data <= acc + prod_x;
            res_row  <= i;
            res_col  <= j;
          end
        end
        EMIT: if (res_ready) begin
          acc <= '0;
          j   <= j == KL ? '0 : j + LW'(1);
          if (j == KL) i <= i + LW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: directed vector table for the 4x4/8-bit engine plus hand sequences for control, reset and an N=2/DW=4 instance.
module tb_matmul_engine;
  logic        clk = 0, rst = 1, start = 0, res_ready = 0;
  logic        busy, done, mem_en, res_valid, res_last;
  logic [10:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [17:0] res_data;
  logic [1:0]  res_row, res_col;
  logic [7:0]  mem1 [2048];

  logic        start2 = 0, res_ready2 = 0;
  logic        busy2, done2, mem_en2, res_valid2, res_last2;
  logic [10:0] mem_addr2;
  logic [3:0]  mem_rdata2;
  logic [8:0]  res_data2;
  logic [0:0]  res_row2, res_col2;
  logic [3:0]  mem2 [2048];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem1[mem_addr];
  always @(posedge clk) if (mem_en2) mem_rdata2 <= mem2[mem_addr2];

  matmul_engine dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .res_last(res_last)
  );

  matmul_engine #(.N(2), .DW(4), .AW(11), .BASE_A(100), .BASE_B(200)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
    .res_row(res_row2), .res_col(res_col2), .res_last(res_last2)
  );

  typedef struct {
    logic [7:0]  a [16];
    logic [7:0]  b [16];
    logic [17:0] c [16];
    int          duty;
    int          restart_at;
    bit          chk_lat;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int v);
    int cyc, got, t;
    logic held, rdy;
    logic [17:0] hd;
    logic [3:0] hrc;
    for (int n = 0; n < 16; n++) begin
      mem1[(n%4)*4 + n/4]      = vecs[v].a[n];
      mem1[16 + (n%4)*4 + n/4] = vecs[v].b[n];
    end
    @(negedge clk);
    start = 1;
    res_ready = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!res_valid && cyc < 100) begin
      if (cyc == vecs[v].restart_at) start = 1;
      @(negedge clk);
      start = 0;
      cyc++;
    end
    if (vecs[v].chk_lat) chk($sformatf("v%0d latency", v), cyc, 38);
    got = 0;
    t = 0;
    held = 0;
    hd = '0;
    hrc = '0;
    while (got < 16 && t < 400) begin
      rdy = vecs[v].duty <= 1 || t % 3 == 0;
      res_ready = rdy;
      if (held) begin
        chk($sformatf("v%0d hold_valid", v), res_valid, 1);
        chk($sformatf("v%0d hold_data", v), res_data, hd);
        chk($sformatf("v%0d hold_rowcol", v), {res_row, res_col}, hrc);
      end
      if (res_valid && rdy) begin
        chk($sformatf("v%0d c[%0d] data", v, got), res_data, vecs[v].c[got]);
        chk($sformatf("v%0d c[%0d] row", v, got), res_row, got / 4);
        chk($sformatf("v%0d c[%0d] col", v, got), res_col, got % 4);
        chk($sformatf("v%0d c[%0d] last", v, got), res_last, got == 15);
        got++;
      end
      held = res_valid && !rdy;
      hd = res_data;
      hrc = {res_row, res_col};
      @(negedge clk);
      t++;
    end
    chk($sformatf("v%0d result_count", v), got, 16);
    chk($sformatf("v%0d done_pulse", v), done, 1);
    chk($sformatf("v%0d valid_after", v), res_valid, 0);
    @(negedge clk);
    chk($sformatf("v%0d done_low", v), done, 0);
    chk($sformatf("v%0d idle", v), busy, 0);
    res_ready = 0;
  endtask

  initial begin
    int cyc, na, got, t, last_t;
    logic bad;
    logic [10:0] exp_addr [8];
    logic [8:0]  exp2 [4];

    for (int n = 0; n < 16; n++) begin
      vecs[0].a[n] = (n/4 == n%4) ? 8'd1 : 8'd0;
      vecs[0].b[n] = 8'(n + 1);
      vecs[0].c[n] = 18'(n + 1);
      vecs[1].a[n] = 8'd255;
      vecs[1].b[n] = 8'd255;
`ifdef MATMUL_SIGNED_EN
      vecs[1].c[n] = 18'd4;
      vecs[3].c[n] = 18'd128;
`else
      vecs[1].c[n] = 18'd260100;
      vecs[3].c[n] = 18'd32640;
`endif
      vecs[2].a[n] = 8'd1;
      vecs[2].b[n] = 8'(n%4 + 1);
      vecs[2].c[n] = 18'(4*(n%4 + 1));
      vecs[3].a[n] = (n/4 == n%4) ? 8'hFF : 8'h00;
      vecs[3].b[n] = 8'h80;
      vecs[4].a[n] = vecs[0].a[n];
      vecs[4].b[n] = vecs[0].b[n];
      vecs[4].c[n] = vecs[0].c[n];
    end
    for (int v = 0; v < 5; v++) begin
      vecs[v].duty = v == 2 ? 3 : 1;
      vecs[v].restart_at = v == 4 ? 35 : -1;
      vecs[v].chk_lat = v == 0 || v == 4;
    end

    repeat (2) @(negedge clk);
    chk("rst busy/done/en/valid/last", {busy, done, mem_en, res_valid, res_last}, 0);
    chk("rst addr/data/row/col", {mem_addr, res_data, res_row, res_col}, 0);
    chk("rst dut2 outputs", {busy2, done2, mem_en2, res_valid2, res_last2, mem_addr2, res_data2}, 0);
    rst = 0;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Abort on LOAD cycle 10.
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("load10 mem_en", mem_en, 1);
    chk("load10 mem_addr", mem_addr, 10);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort busy/en/valid", {busy, mem_en, res_valid}, 0);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || mem_en || res_valid) bad = 1;
    end
    chk("abort stays quiet", bad, 0);

    // start coinciding with rst is dropped.
    rst = 1;
    start = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    chk("start with rst", busy, 0);
    @(negedge clk);
    chk("start with rst later", busy, 0);

    run_vec(0);

    // N=2, DW=4 instance.
    exp_addr = '{11'd100, 11'd101, 11'd102, 11'd103, 11'd200, 11'd201, 11'd202, 11'd203};
    exp2 = '{9'd50, 9'd21, 9'd38, 9'd38};
    mem2[100] = 4'd7; mem2[101] = 4'd3; mem2[102] = 4'd2; mem2[103] = 4'd5;
    mem2[200] = 4'd6; mem2[201] = 4'd4; mem2[202] = 4'd1; mem2[203] = 4'd7;
    @(negedge clk);
    start2 = 1;
    res_ready2 = 1;
    @(negedge clk);
    start2 = 0;
    cyc = 1;
    na = 0;
    while (!res_valid2 && cyc < 60) begin
      if (mem_en2) begin
        if (na < 8) chk($sformatf("n2 addr[%0d]", na), mem_addr2, exp_addr[na]);
        na++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("n2 read count", na, 8);
    chk("n2 latency", cyc, 12);
    got = 0;
    t = 0;
    last_t = 0;
    while (got < 4 && t < 50) begin
      if (res_valid2) begin
        chk($sformatf("n2 c[%0d] data", got), res_data2, exp2[got]);
        chk($sformatf("n2 c[%0d] rowcol", got), {res_row2, res_col2}, got);
        chk($sformatf("n2 c[%0d] last", got), res_last2, got == 3);
        if (got > 0) chk($sformatf("n2 period[%0d]", got), t - last_t, 3);
        last_t = t;
        got++;
      end
      @(negedge clk);
      t++;
    end
    chk("n2 result_count", got, 4);
    chk("n2 done_pulse", done2, 1);
    @(negedge clk);
    chk("n2 idle", {busy2, done2}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
